// File: rtl/ram_separate_io_if.sv
// Bus bundle for ram_separate_io: shared address, write strobe, separate data in/out.
// The master drives address/write side; the RAM (slave) drives the read data.
interface ram_separate_io_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();

    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/ram_separate_io.sv
// Single-port RAM: synchronous write, read gated by per-word valid flags that reset clears.
// Define RAM_OUT_REG_EN to register data_out (1-cycle read latency, read-before-write).
module ram_separate_io #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_separate_io_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] read_data_s;

    // Qualified write strobe: no write can land while reset is held.
    always_comb begin
        wr_en_s = rst_n & bus.we;
    end

    // Storage array; deliberately not reset, the valid flags mask stale contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram[bus.addr] <= bus.data_in;
        end
    end

    // Per-word valid flags, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= {DEPTH{1'b0}};
        end else if (bus.we) begin
            valid[bus.addr] <= 1'b1;
        end
    end

    // Read mux sees pre-edge contents, giving read-before-write behaviour.
    always_comb begin
        read_data_s = {DATA_WIDTH{1'b0}};
        if (rst_n && valid[bus.addr]) begin
            read_data_s = ram[bus.addr];
        end else begin
            read_data_s = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] data_out_r;

    // Output register samples the read mux on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            data_out_r <= read_data_s;
        end
    end

    assign bus.data_out = data_out_r;
`else
    assign bus.data_out = read_data_s;
`endif

endmodule

// File: tb/tb_ram_separate_io.sv
// Self-checking bench for ram_separate_io: directed scenarios plus randomized traffic
// checked against an associative-array memory model (missing key = never written = 0).
module tb_ram_separate_io;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [7:0] model [int];

    ram_separate_io_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    ram_separate_io #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input int a);
        if (model.exists(a)) return model[a];
        return 8'h00;
    endfunction

    // One write cycle; leaves we high so successive calls write on consecutive edges.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.we      = 1'b1;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        model[int'(a)] = d;
        #1;
        check_val("ram_hier", dut.ram[a], d);
    endtask

    // Read with we low; in the registered build wait for the capturing edge.
    task automatic read_check(input string tag, input logic [7:0] a);
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = a;
`ifdef RAM_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
        check_val(tag, bus.data_out, model_rd(int'(a)));
    endtask

    initial begin
        logic [7:0] exp_reg;
        logic [7:0] ra;
        logic [7:0] rd;
        logic       rw;
        n_cmp       = 0;
        n_err       = 0;
        bus.we      = 1'b0;
        bus.addr    = 8'h00;
        bus.data_in = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out", bus.data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("after_reset_rd", 8'h10);

        // Reset clear: mid-cycle async reset wipes visibility of written data
        do_write(8'h10, 8'hA5);
        read_check("pre_reset_rd", 8'h10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model.delete();
        #1;
        check_val("async_clear", bus.data_out, 8'h00);
        bus.we      = 1'b1;
        bus.addr    = 8'h12;
        bus.data_in = 8'h99;
        @(posedge clk);
        #1;
        check_val("in_reset_out", bus.data_out, 8'h00);
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        read_check("post_reset_10", 8'h10);
        read_check("no_write_in_reset", 8'h12);

        // Basic write/read
        do_write(8'h01, 8'h3C);
        do_write(8'hFE, 8'hC3);
        read_check("basic_01", 8'h01);
        read_check("basic_FE", 8'hFE);

        // Read-before-write
        do_write(8'h20, 8'h11);
        @(negedge clk);
        bus.we      = 1'b1;
        bus.addr    = 8'h20;
        bus.data_in = 8'h22;
`ifdef RAM_OUT_REG_EN
        @(posedge clk);
        #1;
        check_val("rbw_reg_old", bus.data_out, 8'h11);
        @(negedge clk);
        bus.we = 1'b0;
        @(posedge clk);
        #1;
        check_val("rbw_reg_new", bus.data_out, 8'h22);
`else
        #1;
        check_val("rbw_old", bus.data_out, 8'h11);
        @(posedge clk);
        #1;
        check_val("rbw_new", bus.data_out, 8'h22);
`endif
        model[32'h20] = 8'h22;

        // Boundaries
        do_write(8'h00, 8'h5A);
        do_write(8'hFF, 8'hFF);
        read_check("bound_00", 8'h00);
        read_check("bound_FF", 8'hFF);
        read_check("bound_nb_01", 8'h01);
        read_check("bound_nb_FE", 8'hFE);

        // Overwrite and isolation
        do_write(8'h40, 8'h01);
        do_write(8'h40, 8'h02);
        do_write(8'h40, 8'h03);
        read_check("overwrite_40", 8'h40);
        read_check("isolate_41", 8'h41);

        // Latency check at the write edge and one edge later
        do_write(8'h08, 8'h77);
`ifdef RAM_OUT_REG_EN
        check_val("lat_write_edge", bus.data_out, 8'h00);
        @(negedge clk);
        bus.we = 1'b0;
        @(posedge clk);
        #1;
        check_val("lat_one_edge", bus.data_out, 8'h77);
`else
        check_val("lat_comb", bus.data_out, 8'h77);
`endif

        // Randomized traffic, mostly in a small window to force address reuse
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rw = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(96, 111));
            rd = 8'($urandom);
            bus.we      = rw;
            bus.addr    = ra;
            bus.data_in = rd;
`ifndef RAM_OUT_REG_EN
            #1;
            check_val("rand_comb", bus.data_out, model_rd(int'(ra)));
`endif
            @(posedge clk);
            exp_reg = model_rd(int'(ra));
            if (rw) model[int'(ra)] = rd;
            #1;
`ifdef RAM_OUT_REG_EN
            check_val("rand_reg", bus.data_out, exp_reg);
`else
            check_val("rand_after", bus.data_out, model_rd(int'(ra)));
`endif
        end

        @(negedge clk);
        bus.we = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_separate_io.md
Name: ram_separate_io

Overview:
- Single-port synchronous-write, asynchronous-read RAM with separate data input and data output buses.
- Generic scratch storage for datapath blocks; one address port is shared by reads and writes.
- Per-word valid flags are cleared by reset, so every word reads as zero after reset without clearing the storage array itself.

Parameters:
- DATA_WIDTH, 8, width of each memory word and of data_in/data_out.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words (256 by default).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all valid flags and the optional output register.
- we  input  1  write enable; 1 = write data_in to ram[addr] on the next rising clk edge.
- addr  input  ADDR_WIDTH  shared read/write word address.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data for addr.

Behaviour:
- Storage:
  - Internal array named ram, 2**ADDR_WIDTH words of DATA_WIDTH bits, declared as a memory so hierarchical reference ram[addr] works.
  - Internal valid vector valid[2**ADDR_WIDTH-1:0], one flop per word.
- Reset (rst_n low, asynchronous, any time):
  - valid cleared to all zeros immediately, independent of clk.
  - ram contents are not cleared; simulation initial contents are zero.
  - While rst_n is low, writes are ignored and data_out = 0.
- Write:
  - On a rising clk edge with rst_n high and we=1: ram[addr] <= data_in and valid[addr] <= 1.
  - Full-word write only; no byte enables.
  - All addresses, including 0 and 2**ADDR_WIDTH-1, are writable.
- Read (default, combinational):
  - data_out = valid[addr] ? ram[addr] : 0.
  - No clock latency: a change on addr is reflected on data_out within the same cycle.
  - Read-before-write inside a cycle: during a cycle with we=1, data_out shows the old contents of ram[addr].
  - After the writing edge, data_out shows data_in while addr is held.
- Back-to-back writes to the same address: the last write wins.
- Writes to one address never disturb any other word.
- X/undefined address is not handled specially and carries no requirement.
- Reset deasserting on or near a clk edge:
  - An edge with rst_n low performs no write.
  - The first edge with rst_n high may write.
- Invariant checked by verification:
  - After any edge with rst_n high and we=1, ram[addr_at_edge] == data_in_at_edge.
  - Whenever rst_n=1, we=0 and valid[addr]=1, data_out == ram[addr] (combinational mode).

Optional Feature:
- Macro: RAM_OUT_REG_EN.
- Defined:
  - data_out is driven by a DATA_WIDTH output register, reset asynchronously to 0 by rst_n.
  - On every rising clk edge with rst_n high, the register loads valid[addr] ? ram[addr] : 0, sampled before that edge's write (read-before-write).
  - Read latency is 1 cycle.
  - The combinational data_out invariant applies to the register one cycle later.
- Not defined: combinational read exactly as described in Behaviour, zero latency.

Test Plan:
- Reset clear:
  - Write 0xA5 to addr 0x10, pulse rst_n low mid-cycle.
  - Required: data_out at addr 0x10 reads 0x00 immediately, without waiting for a clock edge.
  - Required: data_out stays 0x00 after rst_n deasserts, until that address is rewritten.
- Basic write/read:
  - Write 0x3C to addr 0x01 and 0xC3 to addr 0xFE, then set we=0.
  - Required: addr 0x01 reads 0x3C, addr 0xFE reads 0xC3, ram[0x01]==0x3C.
- Read-before-write:
  - Hold addr=0x20 containing 0x11, set we=1, data_in=0x22.
  - Required: data_out=0x11 before the edge and 0x22 after it.
- Boundaries:
  - Write 0x5A to addr 0x00 and 0xFF to addr 0xFF.
  - Required: both read back correctly, and neighbouring addresses 0x01 and 0xFE are unchanged.
- Overwrite and isolation:
  - Write 0x01, 0x02, 0x03 on consecutive cycles to addr 0x40.
  - Required: addr 0x40 reads 0x03, and unwritten addr 0x41 reads 0x00.
- RAM_OUT_REG_EN build:
  - Write 0x77 to addr 0x08, then set we=0 with addr=0x08.
  - Required: data_out=0x77 exactly one edge later.
  - Required: asserting rst_n forces data_out to 0x00 asynchronously.
